per_ker_clk_sel_seq: RTL
========================

# per_ker_clk_sel_seq

Sequencer for glitch-free switching of a peripheral's kernel clock source. It sits in the RCC next to each peripheral's kernel clock gate. Software selection writes are never applied directly to the kernel mux: the sequencer gates the kernel clock off, waits for the target source to report ready, applies the new select, lets the mux settle, then re-enables the gate.

## Interface
Parameters:
- KER_CLK_SRC_NUM, 5: number of selectable kernel sources.
- RST_SEL, 0: select value applied at reset.
- OFF_CYCLES, 4: gate-off hold before switching (≥1).
- SETTLE_CYCLES, 4: post-switch settle before re-enable (≥1).
- TIMEOUT_CYCLES, 1024: maximum wait for source ready (≥1; used only with timeout macro).

SEL_W = max($clog2(KER_CLK_SRC_NUM), 1).

Ports:
- i_clk  in  1  RCC bus clock; all logic in this single domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sel_wr  in  1  single-cycle pulse: software wrote a new select.
- sel_wdata  in  SEL_W  requested select, valid with sel_wr.
- src_rdy  in  KER_CLK_SRC_NUM  per-source ready flags, already synchronized to i_clk.
- err_clr  in  1  clears sticky error flags.
- ker_clk_sel  out  SEL_W  applied select to the kernel mux (registered).
- ker_gate_en  out  1  enable to the kernel clock gate (registered).
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence ends (switch or abort).
- err_sel  out  1  sticky: out-of-range select rejected.
- err_tmo  out  1  sticky: target source ready timeout.

## Operation
- States: IDLE, GATE_OFF, WAIT_RDY, SETTLE.
- IDLE: ker_gate_en=1, busy=0. Accepts a sel_wr, or a pending request.
  - Request ≥ KER_CLK_SRC_NUM: dropped; err_sel set; no state change.
  - Request == ker_clk_sel: dropped silently; no done pulse.
  - Otherwise: target latched; go to GATE_OFF.
- GATE_OFF: ker_gate_en=0; counter loaded OFF_CYCLES-1; on 0 go to WAIT_RDY.
- WAIT_RDY: ker_gate_en=0.
  - If src_rdy[target]: ker_clk_sel←target; counter loaded SETTLE_CYCLES-1; go to SETTLE.
  - If timed out (macro on): abort. ker_clk_sel unchanged, err_tmo set, done pulsed, return to IDLE.
- SETTLE: ker_gate_en=0; on counter 0 go to IDLE with done pulsed.
- sel_wr while busy: stored in a one-deep pending register, latest write wins. Serviced on the first IDLE cycle. A range check applies at service time.
- The target never changes mid-sequence.
- err_clr and a simultaneous error set: set wins.
- rst_n low mid-sequence: immediately ker_clk_sel=RST_SEL, ker_gate_en=1, state IDLE, pending cleared.

## Timing
Reset values: ker_clk_sel=RST_SEL, ker_gate_en=1, busy=0, done=0, err_sel=0, err_tmo=0.

Normal switch, with sel_wr in cycle 0 and the target already ready:
- Cycles 1..OFF_CYCLES: GATE_OFF.
- Cycle OFF_CYCLES+1: WAIT_RDY.
- Next SETTLE_CYCLES cycles: SETTLE, new ker_clk_sel visible from the first of them.
- Then IDLE: ker_gate_en=1, done=1 in that cycle.
- With defaults: busy in cycles 1–9, new select from cycle 6, gate and done in cycle 10.

Other timing rules:
- ker_gate_en falls in the same cycle busy rises. ker_clk_sel never changes while ker_gate_en=1.
- Timeout: abort after exactly TIMEOUT_CYCLES cycles in WAIT_RDY.
- Pending request: serviced one cycle after done, i.e. the IDLE cycle is visible.
- err_sel sets in the cycle after the offending request is evaluated.

## Configuration
PER_KER_SEL_TIMEOUT_EN:
- Defined: timeout counter and err_tmo logic present.
- Undefined: WAIT_RDY waits indefinitely; err_tmo tied 0; TIMEOUT_CYCLES ignored.

## Structure
- Package per_ker_clk_pkg:
  - state enum (IDLE, GATE_OFF, WAIT_RDY, SETTLE);
  - SEL_W helper function;
  - counter width = $clog2 of max(OFF_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)+1.
- One sub-module: per_ker_seq_cnt, a loadable down-counter with zero flag, shared by all wait states.

## Test plan
- Reset release, then sel_wr=2 at cycle 0, src_rdy=all 1, defaults: ker_gate_en=0 in cycles 1–9, ker_clk_sel=2 from cycle 6, ker_gate_en=1 and done in cycle 10.
- sel_wr=3 with src_rdy[3]=0, then src_rdy[3]=1 asserted 20 cycles later: WAIT_RDY holds until then; select applies the next cycle; no err_tmo.
- Macro on, TIMEOUT_CYCLES=8, src_rdy[1] held 0, sel_wr=1: abort after 8 WAIT_RDY cycles; ker_clk_sel unchanged; err_tmo=1; done pulses; err_clr then clears err_tmo.
- sel_wr=7 with KER_CLK_SRC_NUM=5: err_sel=1; busy stays 0. A later sel_wr equal to the current select produces no activity.
- sel_wr=1 then sel_wr=4 then sel_wr=2, the last two while busy: after the first switch to 1 completes, one IDLE cycle, then a switch to 2 only.
- rst_n pulsed low during SETTLE: outputs return to reset values asynchronously; after release, no pending sequence runs.

Source files
------------

// File: rtl/per_ker_clk_pkg.sv
// Shared types and sizing helpers for the per-peripheral kernel clock
// select sequencer.
package per_ker_clk_pkg;

    // Sequencer states; also exported on the debug state output.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        WAIT_RDY = 2'd2,
        SETTLE   = 2'd3
    } seq_state_t;

    // Select width: enough bits for n sources, never less than one.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width: must hold the largest load value of any wait state.
    function automatic int cnt_w(input int off_n, input int settle_n, input int tmo_n);
        int m;
        m = off_n;
        if (settle_n > m) m = settle_n;
        if (tmo_n > m) m = tmo_n;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/per_ker_clk_sel_seq_if.sv
// Software-facing select port and kernel clock control of the sequencer.
//
// Handshake: sel_wr is a single-cycle pulse with no back-pressure; sel_wdata
// is valid only while sel_wr=1. A write that arrives while busy=1 is parked
// in a one-deep pending slot (latest wins). done pulses for one cycle when a
// sequence ends, whether by switching or by abort.
interface per_ker_clk_sel_seq_if
    import per_ker_clk_pkg::*;
#(
    parameter int KER_CLK_SRC_NUM = 5
);
    localparam int SEL_W = sel_w(KER_CLK_SRC_NUM);

    logic                       sel_wr;
    logic [SEL_W-1:0]           sel_wdata;
    logic [KER_CLK_SRC_NUM-1:0] src_rdy;
    logic                       err_clr;
    logic [SEL_W-1:0]           ker_clk_sel;
    logic                       ker_gate_en;
    logic                       busy;
    logic                       done;
    logic                       err_sel;
    logic                       err_tmo;
    seq_state_t                 dbg_state;

    modport master (
        output sel_wr, sel_wdata, src_rdy, err_clr,
        input  ker_clk_sel, ker_gate_en, busy, done, err_sel, err_tmo, dbg_state
    );

    modport slave (
        input  sel_wr, sel_wdata, src_rdy, err_clr,
        output ker_clk_sel, ker_gate_en, busy, done, err_sel, err_tmo, dbg_state
    );

endinterface

// File: rtl/per_ker_seq_cnt.sv
// Loadable down-counter with zero flag, shared by every timed wait state of
// the sequencer. A load wins over counting; the count stops at zero.
module per_ker_seq_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load a new delay or count down towards zero.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/per_ker_clk_sel_seq.sv
// Glitch-free kernel clock source switch sequencer: gate off, wait for the
// target source ready, apply the select, settle, gate back on.
// Optional feature macro: PER_KER_SEL_TIMEOUT_EN (ready-wait timeout + err_tmo).
module per_ker_clk_sel_seq
    import per_ker_clk_pkg::*;
#(
    parameter int KER_CLK_SRC_NUM = 5,
    parameter int RST_SEL         = 0,
    parameter int OFF_CYCLES      = 4,
    parameter int SETTLE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic                    i_clk,
    input logic                    rst_n,
    per_ker_clk_sel_seq_if.slave   bus
);

    localparam int          SEL_W   = sel_w(KER_CLK_SRC_NUM);
    localparam int          CNT_W   = cnt_w(OFF_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned SRC_NUM = KER_CLK_SRC_NUM;

    localparam logic [CNT_W-1:0] OFF_LD    = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef PER_KER_SEL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    seq_state_t       state;
    logic [SEL_W-1:0] tgt;
    logic [SEL_W-1:0] sel_q;
    logic             gate_q;
    logic             busy_q;
    logic             done_q;
    logic             err_sel_q;
    logic             pend_vld;
    logic [SEL_W-1:0] pend_sel;

    logic             req_vld;
    logic [SEL_W-1:0] req_sel;
    logic             req_bad;
    logic             req_same;
    logic             tgt_rdy;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;

    // A fresh write in IDLE overrides anything left pending.
    assign req_vld  = bus.sel_wr | pend_vld;
    assign req_sel  = bus.sel_wr ? bus.sel_wdata : pend_sel;
    assign req_bad  = (32'(req_sel) >= SRC_NUM);
    assign req_same = (req_sel == sel_q);
    assign tgt_rdy  = bus.src_rdy[tgt];

    // Counter load on entry to each timed state.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (req_vld && !req_bad && !req_same) begin
                    cnt_load = 1'b1;
                    cnt_val  = OFF_LD;
                end
            end
            GATE_OFF: begin
`ifdef PER_KER_SEL_TIMEOUT_EN
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = TMO_LD;
                end
`endif
            end
            WAIT_RDY: begin
                if (tgt_rdy) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETTLE_LD;
                end
            end
            default: begin
            end
        endcase
    end

    per_ker_seq_cnt #(.W(CNT_W)) u_cnt (
        .i_clk    (i_clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

`ifdef PER_KER_SEL_TIMEOUT_EN
    logic err_tmo_q;
`endif

    // Sequencer FSM with registered outputs, pending slot and sticky errors.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= SEL_W'(RST_SEL);
            sel_q     <= SEL_W'(RST_SEL);
            gate_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_sel_q <= 1'b0;
            pend_vld  <= 1'b0;
            pend_sel  <= '0;
`ifdef PER_KER_SEL_TIMEOUT_EN
            err_tmo_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // Clear first so a same-cycle error set below takes priority.
            if (bus.err_clr) err_sel_q <= 1'b0;
`ifdef PER_KER_SEL_TIMEOUT_EN
            if (bus.err_clr) err_tmo_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    pend_vld <= 1'b0;
                    if (req_vld) begin
                        if (req_bad) begin
                            err_sel_q <= 1'b1;
                        end else if (!req_same) begin
                            tgt    <= req_sel;
                            state  <= GATE_OFF;
                            gate_q <= 1'b0;
                            busy_q <= 1'b1;
                        end
                    end
                end
                GATE_OFF: begin
                    if (cnt_zero) state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (tgt_rdy) begin
                        sel_q <= tgt;
                        state <= SETTLE;
                    end
`ifdef PER_KER_SEL_TIMEOUT_EN
                    else if (cnt_zero) begin
                        err_tmo_q <= 1'b1;
                        done_q    <= 1'b1;
                        gate_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
`endif
                end
                SETTLE: begin
                    if (cnt_zero) begin
                        done_q <= 1'b1;
                        gate_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Writes during a sequence are parked; the target stays fixed.
            if (state != IDLE && bus.sel_wr) begin
                pend_vld <= 1'b1;
                pend_sel <= bus.sel_wdata;
            end
        end
    end

    assign bus.ker_clk_sel = sel_q;
    assign bus.ker_gate_en = gate_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_sel     = err_sel_q;
    assign bus.dbg_state   = state;
`ifdef PER_KER_SEL_TIMEOUT_EN
    assign bus.err_tmo     = err_tmo_q;
`else
    assign bus.err_tmo     = 1'b0;
`endif

endmodule
